// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and constants for the interrupt controller:
//               FSM state encoding, "no source" ID, peripheral source indices
//               and a fixed-priority pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        GAP     = 2'd2
    } irq_state_t;

    localparam logic [2:0] IRQ_ID_NONE = 3'd7;

    localparam int IRQ_UART  = 0;
    localparam int IRQ_TIMER = 1;
    localparam int IRQ_MEAS  = 2;
    localparam int IRQ_GPIO  = 3;

    // Index of the lowest set bit (bit 0 wins); IRQ_ID_NONE when empty.
    function automatic logic [2:0] lowest_set(input logic [6:0] vec);
        logic [2:0] id;
        id = IRQ_ID_NONE;
        for (int i = 6; i >= 0; i--) begin
            if (vec[i]) id = 3'(i);
        end
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller_if
// Description : Interrupt bundle between the register block / peripherals
//               (master) and the interrupt controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_controller_if #(
    parameter int NUM_IRQS = 4
);
    logic [NUM_IRQS-1:0] irq_sources;
    logic [NUM_IRQS-1:0] irq_mask;
    logic [NUM_IRQS-1:0] irq_edge_sel;
    logic [NUM_IRQS-1:0] pending_clr;
    logic                irq_ack;
    logic                irq_out;
    logic [2:0]          active_id;
    logic [NUM_IRQS-1:0] irq_pending;
    logic                in_service;

    modport master (
        output irq_sources, irq_mask, irq_edge_sel, pending_clr, irq_ack,
        input  irq_out, active_id, irq_pending, in_service
    );

    modport slave (
        input  irq_sources, irq_mask, irq_edge_sel, pending_clr, irq_ack,
        output irq_out, active_id, irq_pending, in_service
    );
endinterface
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Single-source synchroniser with delayed copy and registered
//               rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_src,
    output logic o_s,
    output logic o_rise
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("irq_sync_edge: SYNC_STAGES must be 2..4");
    end

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   r_prev_q;
    logic                   r_rise_q;
    logic                   w_rise_d;

    // Shift the raw source through the chain and form the edge term.
    always_comb begin
        w_sync_d = {r_sync_q[SYNC_STAGES-2:0], i_src};
        w_rise_d = r_sync_q[SYNC_STAGES-1] & ~r_prev_q;
    end

    // Rise is registered so an edge reaches pending SYNC_STAGES+1 edges after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_q <= '0;
            r_prev_q <= 1'b0;
            r_rise_q <= 1'b0;
        end else begin
            r_sync_q <= w_sync_d;
            r_prev_q <= r_sync_q[SYNC_STAGES-1];
            r_rise_q <= w_rise_d;
        end
    end

    assign o_s    = r_sync_q[SYNC_STAGES-1];
    assign o_rise = r_rise_q;

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Synchronises interrupt sources, latches pending bits
//               (edge or level), masks, arbitrates by fixed priority and
//               holds the winner on irq_out until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    irq_controller_if.slave  bus
);

    if (NUM_IRQS < 1 || NUM_IRQS > 7) begin : g_bad_num_irqs
        $error("irq_controller: NUM_IRQS must be 1..7");
    end

    logic [NUM_IRQS-1:0] w_s;
    logic [NUM_IRQS-1:0] w_rise;
    logic [NUM_IRQS-1:0] r_pending_q;
    logic [NUM_IRQS-1:0] w_pending_d;
    logic [NUM_IRQS-1:0] w_cand;
    logic [7:0]          w_cand_ext;
    logic [2:0]          w_winner;
    logic                w_ack_accept;

    irq_state_t          r_state_q;
    irq_state_t          w_state_d;
    logic                r_irq_out_q;
    logic                w_irq_out_d;
    logic [2:0]          r_active_id_q;
    logic [2:0]          w_active_id_d;

    for (genvar gi = 0; gi < NUM_IRQS; gi++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk    (clk),
            .rst    (rst),
            .i_src  (bus.irq_sources[gi]),
            .o_s    (w_s[gi]),
            .o_rise (w_rise[gi])
        );
    end

    assign w_ack_accept = bus.irq_ack && (r_state_q == SERVICE);
    assign w_cand       = r_pending_q & bus.irq_mask;
    assign w_cand_ext   = 8'(w_cand);
    assign w_winner     = lowest_set(w_cand_ext[6:0]);

    // Pending next state: edge bits latch rises (set beats clear), level bits follow s.
    always_comb begin
        w_pending_d = r_pending_q;
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (bus.irq_edge_sel[i]) begin
                if (w_rise[i]) begin
                    w_pending_d[i] = 1'b1;
                end else if (bus.pending_clr[i] ||
                             (w_ack_accept && (r_active_id_q == 3'(i)))) begin
                    w_pending_d[i] = 1'b0;
                end
            end else begin
                w_pending_d[i] = w_s[i];
            end
        end
    end

    // Service FSM next state; outputs are computed here and registered with the state.
    always_comb begin
        w_state_d     = r_state_q;
        w_irq_out_d   = r_irq_out_q;
        w_active_id_d = r_active_id_q;
        case (r_state_q)
            IDLE: begin
                if (w_cand != '0) begin
                    w_state_d     = SERVICE;
                    w_irq_out_d   = 1'b1;
                    w_active_id_d = w_winner;
                end
            end
            SERVICE: begin
                // Ack takes precedence over a simultaneous withdraw.
                if (bus.irq_ack) begin
                    w_state_d     = GAP;
                    w_irq_out_d   = 1'b0;
                    w_active_id_d = IRQ_ID_NONE;
                end else if (!w_cand_ext[r_active_id_q]) begin
                    w_state_d     = IDLE;
                    w_irq_out_d   = 1'b0;
                    w_active_id_d = IRQ_ID_NONE;
                end
            end
            GAP: begin
                w_state_d     = IDLE;
                w_irq_out_d   = 1'b0;
                w_active_id_d = IRQ_ID_NONE;
            end
            default: begin
                w_state_d     = IDLE;
                w_irq_out_d   = 1'b0;
                w_active_id_d = IRQ_ID_NONE;
            end
        endcase
    end

    // State, output and pending registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_irq_out_q   <= 1'b0;
            r_active_id_q <= IRQ_ID_NONE;
            r_pending_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_irq_out_q   <= w_irq_out_d;
            r_active_id_q <= w_active_id_d;
            r_pending_q   <= w_pending_d;
        end
    end

    assign bus.irq_out     = r_irq_out_q;
    assign bus.active_id   = r_active_id_q;
    assign bus.irq_pending = r_pending_q;
    assign bus.in_service  = (r_state_q == SERVICE);

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;
    import irq_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    irq_controller_if #(.NUM_IRQS(4)) bus ();

    irq_controller #(
        .NUM_IRQS    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Source high for exactly one sampling edge; returns just after that edge (T0).
    task automatic pulse_src(input logic [3:0] m);
        bus.irq_sources = m;
        tick();
        bus.irq_sources = 4'h0;
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic o, input logic [2:0] id);
        check({tag, "_out"}, 8'(bus.irq_out), 8'(o));
        check({tag, "_id"},  8'(bus.active_id), 8'(id));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.irq_sources  = 4'h0;
        bus.irq_mask     = 4'hF;
        bus.irq_edge_sel = 4'hF;
        bus.pending_clr  = 4'h0;
        bus.irq_ack      = 1'b0;
        ticks(2);
        chk_out("rst", 1'b0, IRQ_ID_NONE);
        check("rst_pend", 8'(bus.irq_pending), 8'h00);
        check("rst_insvc", 8'(bus.in_service), 8'h00);
        rst = 1'b0;
        ticks(2);

        // 1: single Timer pulse, exact latency, hold, ack, gap
        pulse_src(4'b0010);                  // T0
        ticks(3);                            // T0+3
        check("t1_pend", 8'(bus.irq_pending), 8'h02);
        chk_out("t1_pre", 1'b0, IRQ_ID_NONE);
        tick();                              // T0+4
        chk_out("t1_rise", 1'b1, 3'd1);
        check("t1_insvc", 8'(bus.in_service), 8'h01);
        ticks(3);
        chk_out("t1_hold", 1'b1, 3'd1);
        ack();
        chk_out("t1_gap", 1'b0, IRQ_ID_NONE);
        check("t1_gap_insvc", 8'(bus.in_service), 8'h00);
        check("t1_pend_clr", 8'(bus.irq_pending), 8'h00);
        ticks(2);
        chk_out("t1_idle", 1'b0, IRQ_ID_NONE);

        // 2: GPIO and UART together, UART first, then GPIO after gap
        pulse_src(4'b1001);
        ticks(4);
        chk_out("t2_first", 1'b1, 3'd0);
        ack();
        chk_out("t2_gap", 1'b0, IRQ_ID_NONE);
        check("t2_pend", 8'(bus.irq_pending), 8'h08);
        tick();
        chk_out("t2_idle", 1'b0, IRQ_ID_NONE);
        tick();
        chk_out("t2_second", 1'b1, 3'(IRQ_GPIO));
        ack();
        ticks(3);
        chk_out("t2_done", 1'b0, IRQ_ID_NONE);
        check("t2_pend_done", 8'(bus.irq_pending), 8'h00);

        // 3: Meas in service, UART arrives, no preemption
        pulse_src(4'b0100);
        ticks(4);
        chk_out("t3_meas", 1'b1, 3'd2);
        pulse_src(4'b0001);
        ticks(5);
        chk_out("t3_nopre", 1'b1, 3'd2);
        check("t3_pend", 8'(bus.irq_pending), 8'h05);
        ack();
        chk_out("t3_gap", 1'b0, IRQ_ID_NONE);
        ticks(2);
        chk_out("t3_uart", 1'b1, 3'd0);
        ack();
        ticks(3);

        // 4: level GPIO, masked off during service -> withdraw
        bus.irq_edge_sel = 4'b0111;
        bus.irq_sources  = 4'b1000;
        ticks(5);
        chk_out("t4_level", 1'b1, 3'd3);
        bus.irq_mask = 4'b0111;
        tick();
        chk_out("t4_withdraw", 1'b0, IRQ_ID_NONE);
        check("t4_pend", 8'(bus.irq_pending), 8'h08);
        check("t4_insvc", 8'(bus.in_service), 8'h00);
        bus.irq_sources = 4'h0;
        ticks(4);
        check("t4_level_drop", 8'(bus.irq_pending), 8'h00);
        bus.irq_mask     = 4'hF;
        bus.irq_edge_sel = 4'hF;
        tick();

        // 5: clear coincident with rise (set wins), ack in IDLE ignored
        bus.irq_mask = 4'h0;
        pulse_src(4'b0010);                  // T0
        ticks(2);                            // T0+2, rise visible to pending logic
        bus.pending_clr = 4'b0010;
        tick();                              // T0+3
        bus.pending_clr = 4'h0;
        check("t5_setwins", 8'(bus.irq_pending), 8'h02);
        ack();
        check("t5_ack_idle_insvc", 8'(bus.in_service), 8'h00);
        chk_out("t5_ack_idle", 1'b0, IRQ_ID_NONE);
        check("t5_ack_idle_pend", 8'(bus.irq_pending), 8'h02);
        bus.pending_clr = 4'b0010;
        tick();
        bus.pending_clr = 4'h0;
        check("t5_clr", 8'(bus.irq_pending), 8'h00);
        bus.irq_mask = 4'hF;
        tick();

        // 6: asynchronous reset mid-service, then normal operation
        pulse_src(4'b0100);
        ticks(5);
        chk_out("t6_svc", 1'b1, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6_async", 1'b0, IRQ_ID_NONE);
        check("t6_pend", 8'(bus.irq_pending), 8'h00);
        check("t6_insvc", 8'(bus.in_service), 8'h00);
        tick();
        rst = 1'b0;
        tick();
        pulse_src(4'b0010);
        ticks(3);
        chk_out("t6_post_pre", 1'b0, IRQ_ID_NONE);
        tick();
        chk_out("t6_post", 1'b1, 3'd1);
        ack();
        chk_out("t6_post_gap", 1'b0, IRQ_ID_NONE);
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
